pipeline_elastic: RTL and testbench
===================================

# pipeline_elastic

Parametrised elastic delay pipeline, the successor to the fixed always-enabled register chain. It carries a LEVEL-deep chain of DATA_WIDTH-bit registers with a per-stage valid bit, valid/ready handshakes on both ends, downstream back-pressure, bubble collapsing and a synchronous flush. It sits between filter and line-buffer stages in the edge-detection datapath, where the consumer can stall.

## Interface
- LEVEL, 3, number of register stages (≥1; LEVEL=0 is illegal and fails elaboration)
- DATA_WIDTH, 2, payload width in bits
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  reset, synchronous, active-high
- inData  in  DATA_WIDTH  upstream payload
- inValid  in  1  upstream payload valid
- inReady  out  1  pipeline accepts inData this cycle
- outData  out  DATA_WIDTH  payload of last stage
- outValid  out  1  last stage holds valid data
- outReady  in  1  downstream accepts outData this cycle
- flush  in  1  discard all in-flight data
- occupancy  out  $clog2(LEVEL+1)  valid stages held (present only with PIPE_OCCUPANCY_EN)

## Operation
- Stage k holds data[k] and valid[k]; stage 0 is fed by inData/inValid, and stage LEVEL-1 drives outData/outValid.
- Advance enable: en[LEVEL] = outReady; en[k] = !valid[k] || en[k+1] for k = LEVEL-1 down to 0 (bubble collapse: an empty stage always loads).
- When en[k]=1: valid[k] <= valid[k-1] (inValid for k=0) and data[k] <= data[k-1] (inData for k=0). When en[k]=0 the stage holds.
- data[k] loads even when the incoming valid is 0. The payload of an invalid stage is don't-care but deterministic.
- inReady = en[0] && !flush. Input transfer = inValid && inReady. Output transfer = outValid && outReady.
- outValid = valid[LEVEL-1] && !flush. outData = data[LEVEL-1].
- flush=1: all valid[k] <= 0 next cycle and data registers are untouched. No input is accepted and no output transfer occurs in the flush cycle. Flush overrides the enables.
- areset=1: all valid[k] <= 0 and data[k] <= 0. Reset takes priority over flush. Mid-stream reset discards in-flight data with no partial output.
- Ordering: data exits in arrival order. No item is duplicated or dropped except by flush or reset.
- Capacity: LEVEL items. When all stages are valid and outReady=0, inReady=0.
- Simultaneous input and output transfer on a full pipeline is allowed. The chain shifts by one and stays full.

## Timing
- Reset values: outValid=0, outData=0, inReady=1 (all stages empty), occupancy=0.
- Latency: an item accepted in cycle t with no stall is visible on outValid/outData in cycle t+LEVEL.
- Throughput: 1 item/cycle while outReady=1.
- Stall: outReady low for S cycles adds S cycles of latency to held items. A bubble ahead of a stall is absorbed: stages behind it keep advancing until they are packed.
- inReady is combinational from outReady through the en chain (a depth-LEVEL AND/OR path). It does not depend combinationally on inValid.
- outValid/outData are combinational only through flush. They carry no combinational path from inValid or inData.

## Configuration
- PIPE_OCCUPANCY_EN defined: the occupancy port and counter exist.
  - Per cycle: +1 on input transfer only, −1 on output transfer only, unchanged on both or neither.
  - Reset and flush drive the count to 0 on the next cycle.
  - The count never exceeds LEVEL.
- PIPE_OCCUPANCY_EN undefined: no port and no counter. Datapath behaviour is identical.

## Structure
- Shared package pipeline_pkg holds the occupancy width function (clog2 of LEVEL+1) and the default LEVEL/DATA_WIDTH constants.
- Sub-module pipe_stage: one register stage with ports aclk, areset, flush, en, dIn, vIn, dOut, vOut. pipeline_elastic instantiates LEVEL of them in a generate loop and builds the en chain.

## Test plan
- Streaming, LEVEL=3, DATA_WIDTH=8, outReady=1: inputs 0x11,0x22,0x33 in cycles 1–3 -> outputs 0x11,0x22,0x33 in cycles 4–6, outValid low otherwise.
- Fill with a stall, LEVEL=3: outReady=0 with inValid held high -> inReady falls after 3 accepts and occupancy=3. Raising outReady drains items in order at 1/cycle.
- Bubble collapse: send A, skip one cycle, send B, with outReady=0 from the cycle A reaches stage 2 -> B packs into stage 1 and inReady stays 1. On release, A and B exit on consecutive cycles.
- Full with simultaneous transfers: pipeline full, inValid=1, outReady=1 for 4 cycles -> 4 items out, 4 items in, occupancy constant at 3.
- Flush mid-stream: 2 items in flight, flush pulsed for 1 cycle alongside inValid=1 -> no transfer in that cycle, outValid=0 afterwards and occupancy=0. The next accepted item exits LEVEL cycles later.
- Reset mid-operation: areset asserted with a full pipeline and outReady=0 -> next cycle outValid=0, outData=0, inReady=1, occupancy=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants and helpers for the elastic delay pipeline.
package pipeline_pkg;

    localparam int DEFAULT_LEVEL      = 3;
    localparam int DEFAULT_DATA_WIDTH = 2;

    // Width of a counter that must hold 0..level inclusive.
    function automatic int occ_width(input int level);
        return (level < 1) ? 1 : $clog2(level + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One register stage of the elastic pipeline: payload plus valid bit.
// Flush clears only the valid bit so the payload stays deterministic.
module pipe_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  flush,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] dIn,
    input  logic                  vIn,
    output logic [DATA_WIDTH-1:0] dOut,
    output logic                  vOut
);

    always_ff @(posedge aclk) begin
        if (areset) begin
            vOut <= 1'b0;
            dOut <= '0;
        end else if (flush) begin
            vOut <= 1'b0;
        end else if (en) begin
            vOut <= vIn;
            dOut <= dIn;
        end
    end

endmodule

// File: rtl/pipeline_elastic.sv
// LEVEL-deep elastic delay pipeline with valid/ready handshakes, bubble
// collapsing and flush. Define PIPE_OCCUPANCY_EN to add the occupancy counter.
module pipeline_elastic
    import pipeline_pkg::*;
#(
    parameter int LEVEL      = DEFAULT_LEVEL,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [DATA_WIDTH-1:0]       inData,
    input  logic                        inValid,
    output logic                        inReady,
    output logic [DATA_WIDTH-1:0]       outData,
    output logic                        outValid,
    input  logic                        outReady,
    input  logic                        flush
`ifdef PIPE_OCCUPANCY_EN
    ,
    output logic [occ_width(LEVEL)-1:0] occupancy
`endif
);

    if (LEVEL < 1) begin : g_level_check
        $error("pipeline_elastic: LEVEL must be at least 1");
    end

    logic [LEVEL-1:0]      valid;
    logic [LEVEL-1:0]      en;
    logic [DATA_WIDTH-1:0] data [LEVEL];

    for (genvar k = 0; k < LEVEL; k++) begin : g_stage
        logic [DATA_WIDTH-1:0] d_in;
        logic                  v_in;

        if (k == 0) begin : g_head
            assign d_in = inData;
            assign v_in = inValid;
        end else begin : g_body
            assign d_in = data[k-1];
            assign v_in = valid[k-1];
        end

        // Unrolled form of en[k] = !valid[k] || en[k+1] with en[LEVEL] = outReady:
        // a stage advances if the sink is ready or any stage at or after it is empty.
        assign en[k] = outReady || !(&valid[LEVEL-1:k]);

        pipe_stage #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_stage (
            .aclk  (aclk),
            .areset(areset),
            .flush (flush),
            .en    (en[k]),
            .dIn   (d_in),
            .vIn   (v_in),
            .dOut  (data[k]),
            .vOut  (valid[k])
        );
    end

    assign inReady  = en[0] && !flush;
    assign outValid = valid[LEVEL-1] && !flush;
    assign outData  = data[LEVEL-1];

`ifdef PIPE_OCCUPANCY_EN
    localparam int OW = occ_width(LEVEL);

    logic          in_xfer;
    logic          out_xfer;
    logic [OW-1:0] occ_q;

    assign in_xfer  = inValid && inReady;
    assign out_xfer = outValid && outReady;

    always_ff @(posedge aclk) begin
        if (areset || flush) begin
            occ_q <= '0;
        end else if (in_xfer && !out_xfer) begin
            occ_q <= occ_q + OW'(1);
        end else if (out_xfer && !in_xfer) begin
            occ_q <= occ_q - OW'(1);
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipeline_elastic.sv
// Directed self-checking bench for pipeline_elastic (LEVEL=3, DATA_WIDTH=8).
module tb_pipeline_elastic;

    localparam int LEVEL = 3;
    localparam int DW    = 8;

    logic          aclk = 1'b0;
    logic          areset;
    logic [DW-1:0] inData;
    logic          inValid;
    logic          inReady;
    logic [DW-1:0] outData;
    logic          outValid;
    logic          outReady;
    logic          flush;
`ifdef PIPE_OCCUPANCY_EN
    logic [1:0]    occupancy;
`endif

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    pipeline_elastic #(
        .LEVEL     (LEVEL),
        .DATA_WIDTH(DW)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .inData   (inData),
        .inValid  (inValid),
        .inReady  (inReady),
        .outData  (outData),
        .outValid (outValid),
        .outReady (outReady),
        .flush    (flush)
`ifdef PIPE_OCCUPANCY_EN
        ,
        .occupancy(occupancy)
`endif
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
        inValid  = v;
        inData   = d;
        outReady = ordy;
        flush    = fl;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ov/ir checked always; outData only when a valid item is expected.
    task automatic co(input string tag, input logic ov, input logic [DW-1:0] od, input logic ir);
        chk({tag, ".outValid"}, 32'(outValid), 32'(ov));
        if (ov) chk({tag, ".outData"}, 32'(outData), 32'(od));
        chk({tag, ".inReady"}, 32'(inReady), 32'(ir));
    endtask

    task automatic occ(input string tag, input int n);
`ifdef PIPE_OCCUPANCY_EN
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(n));
`else
        if (n < 0) $display("occupancy %s %0d", tag, n);
`endif
    endtask

    initial begin
        areset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst.outValid", 32'(outValid), 32'd0);
        chk("rst.outData", 32'(outData), 32'h0);
        chk("rst.inReady", 32'(inReady), 32'd1);
        occ("rst", 0);
        areset = 1'b0;

        // Streaming: 11,22,33 in cycles 1-3, out in cycles 4-6
        drive(1'b1, 8'h11, 1'b1, 1'b0); co("s1", 1'b0, 8'h00, 1'b1); tick();
        drive(1'b1, 8'h22, 1'b1, 1'b0); co("s2", 1'b0, 8'h00, 1'b1); tick();
        drive(1'b1, 8'h33, 1'b1, 1'b0); co("s3", 1'b0, 8'h00, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0); co("s4", 1'b1, 8'h11, 1'b1); occ("s4", 3); tick();
        co("s5", 1'b1, 8'h22, 1'b1); occ("s5", 2); tick();
        co("s6", 1'b1, 8'h33, 1'b1); occ("s6", 1); tick();
        co("s7", 1'b0, 8'h00, 1'b1); occ("s7", 0);

        // Fill with a stall, then drain in order
        drive(1'b1, 8'hA1, 1'b0, 1'b0); co("f1", 1'b0, 8'h00, 1'b1); tick();
        drive(1'b1, 8'hA2, 1'b0, 1'b0); co("f2", 1'b0, 8'h00, 1'b1); tick();
        drive(1'b1, 8'hA3, 1'b0, 1'b0); co("f3", 1'b0, 8'h00, 1'b1); tick();
        drive(1'b1, 8'hA4, 1'b0, 1'b0); co("f4", 1'b1, 8'hA1, 1'b0); occ("f4", 3); tick();
        co("f5", 1'b1, 8'hA1, 1'b0); occ("f5", 3); tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0); co("f6", 1'b1, 8'hA1, 1'b1); tick();
        co("f7", 1'b1, 8'hA2, 1'b1); tick();
        co("f8", 1'b1, 8'hA3, 1'b1); tick();
        co("f9", 1'b0, 8'h00, 1'b1); occ("f9", 0);

        // Bubble collapse: A, gap, B; stall once A sits in the last stage
        drive(1'b1, 8'hA5, 1'b1, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
        drive(1'b1, 8'h5A, 1'b1, 1'b0); co("b2", 1'b0, 8'h00, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0); co("b3", 1'b1, 8'hA5, 1'b1); tick();
        co("b4", 1'b1, 8'hA5, 1'b1); occ("b4", 2); tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0); co("b5", 1'b1, 8'hA5, 1'b1); tick();
        co("b6", 1'b1, 8'h5A, 1'b1); tick();
        co("b7", 1'b0, 8'h00, 1'b1); occ("b7", 0);

        // Full pipeline with simultaneous in/out transfers for 4 cycles
        drive(1'b1, 8'hC1, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hC2, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hC3, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hC4, 1'b1, 1'b0); co("p1", 1'b1, 8'hC1, 1'b1); occ("p1", 3); tick();
        drive(1'b1, 8'hC5, 1'b1, 1'b0); co("p2", 1'b1, 8'hC2, 1'b1); occ("p2", 3); tick();
        drive(1'b1, 8'hC6, 1'b1, 1'b0); co("p3", 1'b1, 8'hC3, 1'b1); occ("p3", 3); tick();
        drive(1'b1, 8'hC7, 1'b1, 1'b0); co("p4", 1'b1, 8'hC4, 1'b1); occ("p4", 3); tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0); co("p5", 1'b1, 8'hC5, 1'b1); occ("p5", 3); tick();
        co("p6", 1'b1, 8'hC6, 1'b1); tick();
        co("p7", 1'b1, 8'hC7, 1'b1); tick();
        co("p8", 1'b0, 8'h00, 1'b1); occ("p8", 0);

        // Flush with two items in flight, one already in the last stage
        drive(1'b1, 8'hD1, 1'b1, 1'b0); tick();
        drive(1'b1, 8'hD2, 1'b1, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
        drive(1'b1, 8'hD3, 1'b1, 1'b1); co("x0", 1'b0, 8'h00, 1'b0); occ("x0", 2); tick();
        drive(1'b1, 8'hD4, 1'b1, 1'b0); co("x1", 1'b0, 8'h00, 1'b1); occ("x1", 0);
        chk("x1.heldData", 32'(outData), 32'hD1);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0); co("x2", 1'b0, 8'h00, 1'b1); tick();
        co("x3", 1'b0, 8'h00, 1'b1); tick();
        co("x4", 1'b1, 8'hD4, 1'b1); tick();
        co("x5", 1'b0, 8'h00, 1'b1);

        // Reset mid-operation with a full, stalled pipeline
        drive(1'b1, 8'hE1, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hE2, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hE3, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0); co("r0", 1'b1, 8'hE1, 1'b0); occ("r0", 3);
        areset = 1'b1;
        tick();
        co("r1", 1'b0, 8'h00, 1'b1);
        chk("r1.outData", 32'(outData), 32'h0);
        occ("r1", 0);
        areset = 1'b0;
        tick();
        co("r2", 1'b0, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
